regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and hazard tracker for the 32×32 register file. Two producers share the register file's single write port: the ALU write-back stage and the memory (load) write-back stage. The block arbitrates between them with a valid/ready handshake and registers the winner onto the write port (`wr`, `reg_id_w`, `data_in`). It also flags read-after-write hazards on the file's two read ports so decode can stall.

## Interface

Parameters:

- `N`, 32, data width per register
- `R`, 32, number of registers
- `ASIZE`, $clog2(R), register address width
- `STARVE`, 3, consecutive denied cycles after which the ALU requester is forced to win

Ports:

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `hold`  in  1  when high, no request is granted
- `a_valid`  in  1  ALU write request valid
- `a_id`  in  ASIZE  ALU destination register
- `a_data`  in  N  ALU result
- `a_ready`  out  1  ALU request accepted this cycle
- `m_valid`  in  1  memory write request valid
- `m_id`  in  ASIZE  memory destination register
- `m_data`  in  N  load data
- `m_ready`  out  1  memory request accepted this cycle
- `wr`  out  1  register file write enable (registered)
- `reg_id_w`  out  ASIZE  register file write address (registered)
- `data_in`  out  N  register file write data (registered)
- `rd_id1`, `rd_id2`  in  ASIZE  register file read addresses being issued
- `hazard1`, `hazard2`  out  1  pending write to the corresponding read address

## Operation

- **Handshake.** A transfer occurs when valid and ready are both high on a rising edge. A requester holds valid, id and data stable until ready.
- **Ready logic.** `a_ready` and `m_ready` are combinational from valid, `hold`, `rst` and the starvation state. At most one is high per cycle. Both are 0 when `rst` or `hold` is high.
- **Arbitration.**
  - MEM has fixed priority over ALU.
  - Exception: if `starve_cnt` == STARVE and `a_valid`=1, ALU wins.
- **Starvation counter.**
  - `starve_cnt` increments, saturating at STARVE, on each cycle where `a_valid`=1, `hold`=0 and the ALU is not granted.
  - It clears on an ALU grant, or when `a_valid`=0.
  - It holds its value while `hold`=1.
- **Write stage.**
  - On a grant, the next edge loads `reg_id_w` and `data_in` from the winner.
  - `wr` is 1 only if the winner's id is nonzero.
  - Writes to register 0 are accepted and dropped: `wr`=0, and the address and data are still loaded.
  - With no grant, `wr` goes to 0 and address/data hold their values.
- **Hazard detection.** `hazardK` (K=1,2) is high when `rd_idK` is nonzero and equals any of:
  - `reg_id_w` with `wr`=1;
  - `a_id` with `a_valid`=1;
  - `m_id` with `m_valid`=1.
  - It is combinational.
- **Same destination.** If both requesters target the same register in the same cycle, MEM writes first and ALU follows. Program order is the producers' responsibility.
- **Reset.** `wr`=0, `reg_id_w`=0, `data_in`=0, `starve_cnt`=0, both ready outputs 0, both hazard outputs 0.
- **Reset mid-operation.** A write staged in the cycle before `rst` rises is performed. A request whose grant coincides with `rst`=1 is not granted, because ready is forced to 0.

## Timing

- Request accepted on edge k → `wr`/`reg_id_w`/`data_in` valid during cycle k+1 → register file commits on edge k+1.
- The register file's registered read returns new data from edge k+2 onward.
- Throughput: one write per cycle, sustained.
- Maximum ALU wait with MEM continuously valid: STARVE+1 cycles.
- A `hold` change takes effect in the same cycle. A write already staged completes regardless of `hold`.

## Test plan

- **Single ALU write.** `a_valid`=1, `a_id`=5, `a_data`=0x1234, MEM idle → `a_ready`=1 in the same cycle; next cycle `wr`=1, `reg_id_w`=5, `data_in`=0x1234; `hazard1`=1 while `rd_id1`=5 across both cycles.
- **Collision.** `a_valid`=`m_valid`=1, `a_id`=3, `m_id`=4 → cycle 0 `m_ready`=1, `a_ready`=0; cycle 1 `wr` to reg 4; after MEM drops, ALU granted; cycle 2 `wr` to reg 3.
- **Starvation.** `m_valid` held high, `a_valid`=1 → `a_ready` first asserts in the 4th cycle (STARVE=3); `m_ready`=0 that cycle; MEM resumes the cycle after.
- **Register 0.** `m_valid`=1, `m_id`=0, `m_data`=0xFFFF → `m_ready`=1, next cycle `wr`=0; `hazard1`=0 for `rd_id1`=0.
- **Hold and reset.**
  - `hold`=1 with both valid → no ready and `wr`=0 for the full hold duration; `starve_cnt` frozen.
  - `rst` pulse with requests pending → ready outputs 0 and `wr`=0 one edge later; `reg_id_w`=0, `data_in`=0.
- **Back-to-back ALU.** ALU ids 1, 2, 3 on consecutive cycles → `wr`=1 three consecutive cycles with `reg_id_w` = 1, 2, 3.

Source files
------------

// File: rtl/regfile_wb_if.sv
// regfile_wb_if
//   Bundles the write-back bus around the register file's single write port.
//   Producer side (ALU / memory write-back) and the register file read-address
//   side are driven by the master. The arbiter is the slave.
//
//   Signals:
//     hold                    stall: no request is granted while high
//     a_valid/a_id/a_data     ALU write request        a_ready  ALU accepted
//     m_valid/m_id/m_data     memory (load) request    m_ready  memory accepted
//     wr/reg_id_w/data_in     registered write port towards the register file
//     rd_id1/rd_id2           read addresses being issued by decode
//     hazard1/hazard2         pending write to the matching read address
//     starve_cnt              debug view of the ALU starvation counter
interface regfile_wb_if #(
  parameter int N     = 32,
  parameter int ASIZE = 5,
  parameter int SW    = 2
);
  logic             hold;
  logic             a_valid;
  logic [ASIZE-1:0] a_id;
  logic [N-1:0]     a_data;
  logic             a_ready;
  logic             m_valid;
  logic [ASIZE-1:0] m_id;
  logic [N-1:0]     m_data;
  logic             m_ready;
  logic             wr;
  logic [ASIZE-1:0] reg_id_w;
  logic [N-1:0]     data_in;
  logic [ASIZE-1:0] rd_id1;
  logic [ASIZE-1:0] rd_id2;
  logic             hazard1;
  logic             hazard2;
  logic [SW-1:0]    starve_cnt;

  modport slave (
    input  hold, a_valid, a_id, a_data, m_valid, m_id, m_data, rd_id1, rd_id2,
    output a_ready, m_ready, wr, reg_id_w, data_in, hazard1, hazard2, starve_cnt
  );

  modport master (
    output hold, a_valid, a_id, a_data, m_valid, m_id, m_data, rd_id1, rd_id2,
    input  a_ready, m_ready, wr, reg_id_w, data_in, hazard1, hazard2, starve_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates the ALU and memory write-back stages onto the register file's
//   single write port and flags read-after-write hazards for decode.
//
//   Ports:
//     clk   clock
//     rst   synchronous, active-high reset
//     bus   regfile_wb_if.slave (requests, write port, hazard outputs)
//
//   Handshake: a request transfers on a rising edge where valid and ready are
//   both high. A requester keeps valid/id/data stable until it sees ready.
//   Ready is combinational and at most one of a_ready/m_ready is high.
module regfile_wb_arbiter #(
  parameter int N      = 32,
  parameter int R      = 32,
  parameter int ASIZE  = $clog2(R),
  parameter int STARVE = 3
) (
  input  logic        clk,
  input  logic        rst,
  regfile_wb_if.slave bus
);
  localparam int SW = $clog2(STARVE + 1);

  logic [SW-1:0]    r_starve_cnt;
  logic             r_wr;
  logic [ASIZE-1:0] r_reg_id_w;
  logic [N-1:0]     r_data_in;

  logic w_a_win;
  logic w_a_ready;
  logic w_m_ready;

  // Memory has fixed priority; a starved ALU request overrides it.
  assign w_a_win   = bus.a_valid && (!bus.m_valid || (r_starve_cnt == SW'(STARVE)));
  assign w_a_ready = !rst && !bus.hold && w_a_win;
  assign w_m_ready = !rst && !bus.hold && bus.m_valid && !w_a_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!bus.hold) begin
      if (!bus.a_valid || w_a_ready)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != SW'(STARVE))
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Register-0 writes are accepted but never asserted on wr; address and data
  // still load so the port always shows the last granted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr       <= 1'b0;
      r_reg_id_w <= '0;
      r_data_in  <= '0;
    end else if (w_a_ready) begin
      r_wr       <= (bus.a_id != '0);
      r_reg_id_w <= bus.a_id;
      r_data_in  <= bus.a_data;
    end else if (w_m_ready) begin
      r_wr       <= (bus.m_id != '0);
      r_reg_id_w <= bus.m_id;
      r_data_in  <= bus.m_data;
    end else begin
      r_wr <= 1'b0;
    end
  end

  // A read address is hazardous if any write to it is staged or requested.
  function automatic logic hit(input logic [ASIZE-1:0] rd);
    return (rd != '0) &&
           ((r_wr && (r_reg_id_w == rd)) ||
            (bus.a_valid && (bus.a_id == rd)) ||
            (bus.m_valid && (bus.m_id == rd)));
  endfunction

  assign bus.a_ready    = w_a_ready;
  assign bus.m_ready    = w_m_ready;
  assign bus.wr         = r_wr;
  assign bus.reg_id_w   = r_reg_id_w;
  assign bus.data_in    = r_data_in;
  assign bus.hazard1    = !rst && hit(bus.rd_id1);
  assign bus.hazard2    = !rst && hit(bus.rd_id2);
  assign bus.starve_cnt = r_starve_cnt;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Bench for regfile_wb_arbiter: directed scenarios followed by randomized
//   traffic, checked against a behavioural model through expected queues.
module tb_regfile_wb_arbiter;
  localparam int N      = 32;
  localparam int ASIZE  = 5;
  localparam int STARVE = 3;
  localparam int CW     = 6;               // {a_ready, m_ready, hz1, hz2, starve[1:0]}
  localparam int WW     = 1 + ASIZE + N;   // {wr, reg_id_w, data_in}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_if #(.N(N), .ASIZE(ASIZE), .SW(2)) bus ();

  regfile_wb_arbiter #(.N(N), .R(32), .ASIZE(ASIZE), .STARVE(STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [CW-1:0] exp_q[$];   // combinational expectations, one per cycle
  logic [WW-1:0] wb_q[$];    // write-port expectations, one per cycle
  int tests = 0;
  int fails = 0;

  // Reference model: the write port's last loaded contents and the ALU
  // starvation count, updated once per driven cycle.
  logic             m_wr;
  logic [ASIZE-1:0] m_id;
  logic [N-1:0]     m_data;
  int               sc;
  logic             last_ar, last_mr;

  function automatic logic pend(input logic [ASIZE-1:0] rd, input logic av,
                                input logic [ASIZE-1:0] aid, input logic mv,
                                input logic [ASIZE-1:0] mid);
    if (rd == 0) return 1'b0;
    return (m_wr && m_id == rd) || (av && aid == rd) || (mv && mid == rd);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic h,
                       input logic av, input logic [ASIZE-1:0] aid, input logic [N-1:0] ad,
                       input logic mv, input logic [ASIZE-1:0] mid, input logic [N-1:0] md,
                       input logic [ASIZE-1:0] r1, input logic [ASIZE-1:0] r2);
    logic ar, mr, h1, h2;
    @(posedge clk);
    #1;
    rst = r; bus.hold = h;
    bus.a_valid = av; bus.a_id = aid; bus.a_data = ad;
    bus.m_valid = mv; bus.m_id = mid; bus.m_data = md;
    bus.rd_id1 = r1; bus.rd_id2 = r2;

    ar = 1'b0; mr = 1'b0;
    if (!r && !h) begin
      if (av && (!mv || sc == STARVE)) ar = 1'b1;
      else if (mv) mr = 1'b1;
    end
    h1 = !r && pend(r1, av, aid, mv, mid);
    h2 = !r && pend(r2, av, aid, mv, mid);
    exp_q.push_back({ar, mr, h1, h2, 2'(sc)});
    wb_q.push_back({m_wr, m_id, m_data});
    last_ar = ar; last_mr = mr;

    if (r) begin
      m_wr = 1'b0; m_id = '0; m_data = '0; sc = 0;
    end else begin
      if (ar) begin
        m_wr = (aid != 0); m_id = aid; m_data = ad;
      end else if (mr) begin
        m_wr = (mid != 0); m_id = mid; m_data = md;
      end else begin
        m_wr = 1'b0;
      end
      if (!h) begin
        if (!av || ar) sc = 0;
        else if (sc < STARVE) sc = sc + 1;
      end
    end
  endtask

  task automatic idle(input logic [ASIZE-1:0] r1);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, r1, '0);
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [CW-1:0] mon_c;
  logic [WW-1:0] mon_w;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_c = exp_q.pop_front();
      check("a_ready",    64'(bus.a_ready),    64'(mon_c[5]));
      check("m_ready",    64'(bus.m_ready),    64'(mon_c[4]));
      check("hazard1",    64'(bus.hazard1),    64'(mon_c[3]));
      check("hazard2",    64'(bus.hazard2),    64'(mon_c[2]));
      check("starve_cnt", 64'(bus.starve_cnt), 64'(mon_c[1:0]));
    end
    if (wb_q.size() > 0) begin
      mon_w = wb_q.pop_front();
      check("wr",       64'(bus.wr),       64'(mon_w[WW-1]));
      check("reg_id_w", 64'(bus.reg_id_w), 64'(mon_w[N +: ASIZE]));
      check("data_in",  64'(bus.data_in),  64'(mon_w[N-1:0]));
    end
  end

  // ---------------- stimulus ----------------
  logic             ap, mp;
  logic [ASIZE-1:0] aid, mid;
  logic [N-1:0]     ad, md;

  initial begin
    rst = 1'b1; bus.hold = 1'b0;
    bus.a_valid = 1'b0; bus.a_id = '0; bus.a_data = '0;
    bus.m_valid = 1'b0; bus.m_id = '0; bus.m_data = '0;
    bus.rd_id1 = '0; bus.rd_id2 = '0;
    m_wr = 1'b0; m_id = '0; m_data = '0; sc = 0;
    last_ar = 1'b0; last_mr = 1'b0;
    repeat (2) @(posedge clk);

    // Reset with requests pending: no grants, outputs cleared.
    drive(1'b1, 1'b0, 1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd9, 32'hBBBB, 5'd7, 5'd9);
    idle('0);

    // Single ALU write, hazard visible across request and staged cycles.
    drive(1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 5'd5, '0);
    idle(5'd5);
    idle(5'd5);

    // Collision: memory first, ALU after memory drops.
    drive(1'b0, 1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
    drive(1'b0, 1'b0, 1'b1, 5'd3, 32'h33, 1'b0, '0, '0, 5'd3, 5'd4);
    idle('0);

    // Starvation: ALU wins on the 4th cycle, memory resumes afterwards.
    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'b0, (i < 4), 5'd6, 32'h66, 1'b1, 5'(10 + i), 32'(i), 5'd6, '0);
    idle('0);

    // Register 0 write is accepted but not written; no hazard on reg 0.
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
    idle('0);

    // Build up starvation, then hold: no grants, counter frozen.
    drive(1'b0, 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd2, 32'h22, 5'd8, 5'd2);
    drive(1'b0, 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd12, 32'h1C, 5'd8, 5'd2);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd13, 32'h1D, 5'd8, 5'd13);
    drive(1'b0, 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd13, 32'h1D, 5'd8, 5'd13);
    drive(1'b0, 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd13, 32'h1D, 5'd8, 5'd13);
    idle('0);

    // Reset right after a staged write: staged write still shows, then clears.
    drive(1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 5'd9, '0);
    drive(1'b1, 1'b0, 1'b1, 5'd11, 32'hB1, 1'b1, 5'd14, 32'hE1, 5'd9, 5'd11);
    idle('0);

    // Back-to-back ALU writes to 1, 2, 3.
    for (int i = 1; i <= 3; i++)
      drive(1'b0, 1'b0, 1'b1, 5'(i), 32'(100 + i), 1'b0, '0, '0, 5'(i), '0);
    idle('0);
    idle('0);

    // Randomized traffic; requesters keep their request until accepted.
    ap = 1'b0; mp = 1'b0;
    aid = '0; mid = '0; ad = '0; md = '0;
    for (int c = 0; c < 600; c++) begin
      if (!ap && $urandom_range(0, 2) != 0) begin
        ap = 1'b1; aid = 5'($urandom_range(0, 7)); ad = $urandom;
      end
      if (!mp && $urandom_range(0, 2) != 0) begin
        mp = 1'b1; mid = 5'($urandom_range(0, 7)); md = $urandom;
      end
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
            ap, aid, ad, mp, mid, md,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (last_ar) ap = 1'b0;
      if (last_mr) mp = 1'b0;
    end
    idle('0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0 || wb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0", exp_q.size(), wb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
